// File: rtl/cache_line_xfer_pkg.sv
// Shared types and default geometry for the cache line transfer engine.
// Line/beat widths are derived from the data RAM bank index width.
package cache_line_xfer_pkg;
    localparam int unsigned BANK_INDEX_WIDTH = 9;
    localparam int unsigned N_BEATS_DEF      = 4;
    localparam int unsigned LINE_IDX_W_DEF   = BANK_INDEX_WIDTH - $clog2(N_BEATS_DEF);
    localparam int unsigned DATA_W_DEF       = 256;

    typedef enum logic [1:0] {IDLE, FILL, WB, DONE} cache_xfer_state_e;
    typedef logic [LINE_IDX_W_DEF-1:0]        line_idx_t;
    typedef logic [$clog2(N_BEATS_DEF)-1:0]   beat_idx_t;
    typedef logic [BANK_INDEX_WIDTH-1:0]      bank_index_t;
endpackage

// File: rtl/cache_xfer_skid_fifo.sv
// Two-entry buffer holding writeback beats between data RAM reads and the memory bus.
module cache_xfer_skid_fifo #(
    parameter int unsigned DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        count,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    // A push into a full buffer is legal only when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/cache_line_xfer.sv
// Line refill / writeback engine between the cache data RAM mc_* port and the memory bus.
// Define CACHE_LINE_XFER_CRITICAL_WORD_EN to start each line at req_beat (wrapping order).
module cache_line_xfer
    import cache_line_xfer_pkg::*;
#(
    parameter int unsigned N_BEATS    = N_BEATS_DEF,
    parameter int unsigned LINE_IDX_W = LINE_IDX_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic                                   req_wb,
    input  logic [LINE_IDX_W-1:0]                  req_line_idx,
    input  logic [$clog2(N_BEATS)-1:0]             req_beat,
    output logic                                   done,
    output logic                                   mc_en,
    output logic                                   mc_rw,
    output logic [LINE_IDX_W+$clog2(N_BEATS)-1:0]  mc_bank_index,
    output logic [DATA_W-1:0]                      mc_din,
    input  logic [DATA_W-1:0]                      mc_dout,
    input  logic                                   mem_rvalid,
    output logic                                   mem_rready,
    input  logic [DATA_W-1:0]                      mem_rdata,
    output logic                                   mem_wvalid,
    input  logic                                   mem_wready,
    output logic [DATA_W-1:0]                      mem_wdata,
    output logic                                   mem_wlast
);
    localparam int unsigned BEAT_W = $clog2(N_BEATS);
    localparam int unsigned CNT_W  = BEAT_W + 1;

    cache_xfer_state_e   state;
    logic [LINE_IDX_W-1:0] line_idx;
    logic [BEAT_W-1:0]   start_beat;
    logic [BEAT_W-1:0]   first_beat;
    logic [BEAT_W-1:0]   beat_pos;
    logic [CNT_W-1:0]    xfer_cnt;
    logic [CNT_W-1:0]    sent_cnt;
    logic                dout_valid;
    logic                rd_now;
    logic                pop;
    logic                issue;
    logic                buf_full;
    logic                buf_empty;
    logic [1:0]          occ;
    logic [2:0]          load;

`ifdef CACHE_LINE_XFER_CRITICAL_WORD_EN
    assign first_beat = req_beat;
`else
    logic unused_ok;
    assign unused_ok  = ^req_beat;
    assign first_beat = '0;
`endif

    assign beat_pos   = start_beat + xfer_cnt[BEAT_W-1:0];
    assign rd_now     = mc_en & ~mc_rw;
    assign mem_wvalid = ~buf_empty;
    assign pop        = mem_wvalid & mem_wready;
    assign mem_wlast  = mem_wvalid && (sent_cnt == CNT_W'(N_BEATS - 1));
    // Buffered + in-flight beats as they will stand after this edge; keeps reads within the 2 slots.
    assign load  = 3'(occ) + 3'(dout_valid) + 3'(rd_now) - 3'(pop);
    assign issue = (state == WB) && (xfer_cnt < CNT_W'(N_BEATS)) && !buf_full && (load < 3'd2);

    cache_xfer_skid_fifo #(.DATA_W(DATA_W)) u_wb_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (dout_valid),
        .din   (mc_dout),
        .pop   (pop),
        .dout  (mem_wdata),
        .count (occ),
        .full  (buf_full),
        .empty (buf_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            done          <= 1'b0;
            mc_en         <= 1'b0;
            mc_rw         <= 1'b0;
            mc_bank_index <= '0;
            mc_din        <= '0;
            mem_rready    <= 1'b0;
            line_idx      <= '0;
            start_beat    <= '0;
            xfer_cnt      <= '0;
            sent_cnt      <= '0;
            dout_valid    <= 1'b0;
        end else begin
            done       <= 1'b0;
            mc_en      <= 1'b0;
            mc_rw      <= 1'b0;
            dout_valid <= rd_now;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        line_idx   <= req_line_idx;
                        start_beat <= first_beat;
                        xfer_cnt   <= '0;
                        sent_cnt   <= '0;
                        req_ready  <= 1'b0;
                        if (req_wb) begin
                            state <= WB;
                        end else begin
                            state      <= FILL;
                            mem_rready <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (xfer_cnt == CNT_W'(N_BEATS)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (mem_rvalid && mem_rready) begin
                        mc_en         <= 1'b1;
                        mc_rw         <= 1'b1;
                        mc_din        <= mem_rdata;
                        mc_bank_index <= {line_idx, beat_pos};
                        xfer_cnt      <= xfer_cnt + CNT_W'(1);
                        if (xfer_cnt == CNT_W'(N_BEATS - 1)) mem_rready <= 1'b0;
                    end
                end
                WB: begin
                    if (issue) begin
                        mc_en         <= 1'b1;
                        mc_bank_index <= {line_idx, beat_pos};
                        xfer_cnt      <= xfer_cnt + CNT_W'(1);
                    end
                    if (pop) begin
                        sent_cnt <= sent_cnt + CNT_W'(1);
                        if (mem_wlast) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
